button_event_decoder: RTL and testbench



---
 rtl/button_event_decoder.sv | 128 ++++++++++++
 tb/tb_button_event_decoder.sv | 136 +++++++++++++
 2 files changed

// File: rtl/button_event_decoder.sv
// Turns a clean, synchronous button level into single-cycle UI events:
// press, release, short click, long press and auto-repeat while held.
module button_event_decoder #(
    parameter int unsigned LONG_COUNT   = 100_000_000,
    parameter int unsigned REPEAT_COUNT = 20_000_000,
    parameter int unsigned CNT_W        = 27
) (
    input  logic clk_in,
    input  logic reset_n,
    input  logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic click_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held
);

    typedef enum logic [1:0] {
        ST_WAIT_RELEASE,
        ST_IDLE,
        ST_PRESSED,
        ST_LONG
    } state_e;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_COUNT - 1);
    localparam bit               REPEAT_EN   = (REPEAT_COUNT != 0);
    localparam logic [CNT_W-1:0] REPEAT_LAST = REPEAT_EN ? CNT_W'(REPEAT_COUNT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             click_q, click_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;
    logic             held_q, held_d;

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        click_d    = 1'b0;
        long_d     = 1'b0;
        repeat_d   = 1'b0;

        unique case (state_q)
            ST_WAIT_RELEASE: begin
                // A press already in progress at reset is swallowed here.
                if (!btn_level) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (btn_level) begin
                    press_d    = 1'b1;
                    hold_cnt_d = '0;
                    state_d    = ST_PRESSED;
                end
            end
            ST_PRESSED: begin
                if (!btn_level) begin
                    release_d = 1'b1;
                    click_d   = 1'b1;
                    state_d   = ST_IDLE;
                end else if (hold_cnt_q == LONG_LAST) begin
                    long_d    = 1'b1;
                    rep_cnt_d = '0;
                    state_d   = ST_LONG;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_ONE;
                end
            end
            ST_LONG: begin
                if (!btn_level) begin
                    release_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (REPEAT_EN && (rep_cnt_q == REPEAT_LAST)) begin
                    repeat_d  = 1'b1;
                    rep_cnt_d = '0;
                end else if (REPEAT_EN) begin
                    rep_cnt_d = rep_cnt_q + CNT_ONE;
                end
            end
            default: state_d = ST_WAIT_RELEASE;
        endcase

        held_d = (state_d == ST_PRESSED) || (state_d == ST_LONG);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: counters are plain flops, so they are reset like the rest of the state.
            state_q    <= ST_WAIT_RELEASE;
            hold_cnt_q <= '0;
            rep_cnt_q  <= '0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            click_q    <= 1'b0;
            long_q     <= 1'b0;
            repeat_q   <= 1'b0;
            held_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
            press_q    <= press_d;
            release_q  <= release_d;
            click_q    <= click_d;
            long_q     <= long_d;
            repeat_q   <= repeat_d;
            held_q     <= held_d;
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign click_pulse   = click_q;
    assign long_pulse    = long_q;
    assign repeat_pulse  = repeat_q;
    assign held          = held_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder: one instance with repeat enabled
// and one with repeat disabled, both fed the same button level.
module tb_button_event_decoder;

    localparam int LONG = 10;
    localparam int REP  = 4;

    logic clk_in  = 1'b0;
    logic reset_n = 1'b0;
    logic btn_level = 1'b0;

    logic a_press, a_release, a_click, a_long, a_repeat, a_held;
    logic z_press, z_release, z_click, z_long, z_repeat, z_held;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_in = ~clk_in;

    button_event_decoder #(.LONG_COUNT(LONG), .REPEAT_COUNT(REP), .CNT_W(4)) dut (
        .clk_in        (clk_in),
        .reset_n       (reset_n),
        .btn_level     (btn_level),
        .press_pulse   (a_press),
        .release_pulse (a_release),
        .click_pulse   (a_click),
        .long_pulse    (a_long),
        .repeat_pulse  (a_repeat),
        .held          (a_held)
    );

    button_event_decoder #(.LONG_COUNT(LONG), .REPEAT_COUNT(0), .CNT_W(4)) dut0 (
        .clk_in        (clk_in),
        .reset_n       (reset_n),
        .btn_level     (btn_level),
        .press_pulse   (z_press),
        .release_pulse (z_release),
        .click_pulse   (z_click),
        .long_pulse    (z_long),
        .repeat_pulse  (z_repeat),
        .held          (z_held)
    );

    // Output vectors ordered {press, release, click, long, repeat, held}.
    function automatic logic [5:0] vec_a();
        return {a_press, a_release, a_click, a_long, a_repeat, a_held};
    endfunction

    function automatic logic [5:0] vec_z();
        return {z_press, z_release, z_click, z_long, z_repeat, z_held};
    endfunction

    task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b (press,release,click,long,repeat,held)",
                      tag, got, exp);
    endtask

    // Expected outputs after edge k of a press whose first edge is E0 (k=0),
    // with btn_level high for edges 0..n-1 and low at edge n.
    function automatic logic [5:0] expect_at(input int k, input int n, input int rep);
        logic p, r, c, l, t, h;
        p = (k == 0);
        h = (k < n);
        r = (k == n);
        c = r && (n <= LONG);
        l = (k < n) && (k == LONG);
        t = (k < n) && (rep != 0) && (k > LONG) && (((k - LONG) % rep) == 0);
        return {p, r, c, l, t, h};
    endfunction

    task automatic step(input logic b, input logic [5:0] exp_a, input logic [5:0] exp_z,
                        input string tag);
        btn_level = b;
        @(posedge clk_in);
        #1;
        check({tag, " rep4"}, vec_a(), exp_a);
        check({tag, " rep0"}, vec_z(), exp_z);
    endtask

    task automatic press_sequence(input int n, input string tag);
        for (int k = 0; k <= n; k++)
            step(k < n, expect_at(k, n, REP), expect_at(k, n, 0), $sformatf("%s k=%0d", tag, k));
    endtask

    initial begin
        repeat (3) @(posedge clk_in);
        #1;
        check("reset rep4", vec_a(), 6'b0);
        check("reset rep0", vec_z(), 6'b0);
        reset_n = 1'b1;
        step(1'b0, 6'b0, 6'b0, "wait_to_idle");

        press_sequence(5, "short_click");
        step(1'b0, 6'b0, 6'b0, "idle_a");

        press_sequence(25, "long_repeat");
        step(1'b0, 6'b0, 6'b0, "idle_b");

        press_sequence(LONG, "threshold_race");
        step(1'b0, 6'b0, 6'b0, "idle_c");

        // Release lands exactly on the would-be third repeat edge.
        press_sequence(22, "repeat_race");
        step(1'b0, 6'b0, 6'b0, "idle_d");

        // 1,0,1: the second press follows the release edge directly.
        press_sequence(1, "b2b_first");
        press_sequence(3, "b2b_second");
        step(1'b0, 6'b0, 6'b0, "idle_e");

        press_sequence(40, "hold40");
        step(1'b0, 6'b0, 6'b0, "idle_f");

        // Reset asserted between edges while in LONG, on a repeat cycle.
        for (int k = 0; k <= 14; k++)
            step(1'b1, expect_at(k, 100, REP), expect_at(k, 100, 0),
                 $sformatf("pre_reset k=%0d", k));
        #2 reset_n = 1'b0;
        #1;
        check("async_reset rep4", vec_a(), 6'b0);
        check("async_reset rep0", vec_z(), 6'b0);
        step(1'b1, 6'b0, 6'b0, "in_reset_0");
        step(1'b1, 6'b0, 6'b0, "in_reset_1");
        reset_n = 1'b1;
        for (int k = 0; k < 30; k++)
            step(1'b1, 6'b0, 6'b0, $sformatf("held_after_reset k=%0d", k));
        step(1'b0, 6'b0, 6'b0, "swallowed_release");
        press_sequence(3, "press_after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
